// File: rtl/inst_mem_responder_if.sv
// Instruction-fetch handshake between the PC/fetch stage (master) and the
// instruction memory responder (slave): request channel plus response channel.
interface inst_mem_responder_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_inst;
   logic              resp_ready;

   modport master (
      output req_valid,
      output req_addr,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_inst
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_inst
   );
endinterface

// File: rtl/inst_mem_responder.sv
// Word-addressed instruction memory that answers fetches with one cycle of
// latency and holds responses under backpressure; a sequential load port fills it.
module inst_mem_responder #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   inst_mem_responder_if.slave  fetch,
   input  logic                 ld_start,
   input  logic                 ld_valid,
   input  logic [DATA_W-1:0]    ld_data,
   input  logic                 ld_last,
   output logic                 ld_active,
   output logic [ADDR_W:0]      ld_count
);

   typedef enum logic [0:0] {
      ST_SERVE = 1'b0,
      ST_LOAD  = 1'b1
   } state_t;

   state_t            state_r;
   logic              ld_active_r;
   logic [ADDR_W-1:0] ptr_r;
   logic [ADDR_W:0]   ld_count_r;
   logic              resp_valid_r;
   logic [DATA_W-1:0] resp_inst_r;
   logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W) - 1];

   logic              load_on_s;
   logic              load_we_s;
   logic              load_done_s;
   logic [ADDR_W-1:0] eff_ptr_s;
   logic [ADDR_W-1:0] ptr_step_s;
   logic [ADDR_W:0]   cnt_step_s;
   logic              req_ready_s;
   logic              accept_s;

   // Load-port write decode, next pointer/count and the fetch handshake.
   always_comb begin
      load_on_s   = 1'b0;
      load_we_s   = 1'b0;
      load_done_s = 1'b0;
      eff_ptr_s   = ptr_r;
      ptr_step_s  = ptr_r;
      cnt_step_s  = ld_count_r;
      req_ready_s = 1'b0;
      accept_s    = 1'b0;

      // ld_start restarts the image at slot 0, even for a word arriving with it.
      if (ld_start) begin
         eff_ptr_s = {ADDR_W{1'b0}};
      end else begin
         eff_ptr_s = ptr_r;
      end

      load_on_s = ld_start || (state_r == ST_LOAD);

      if (!rst && load_on_s && ld_valid) begin
         load_we_s   = 1'b1;
         load_done_s = ld_last || (eff_ptr_s == {ADDR_W{1'b1}});
         ptr_step_s  = eff_ptr_s + {{(ADDR_W-1){1'b0}}, 1'b1};
         cnt_step_s  = {1'b0, eff_ptr_s} + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
         load_we_s   = 1'b0;
         load_done_s = 1'b0;
         ptr_step_s  = eff_ptr_s;
         if (ld_start) begin
            cnt_step_s = {(ADDR_W+1){1'b0}};
         end else begin
            cnt_step_s = ld_count_r;
         end
      end

      if (!rst && (state_r == ST_SERVE) && !ld_start &&
          (!resp_valid_r || fetch.resp_ready)) begin
         req_ready_s = 1'b1;
      end else begin
         req_ready_s = 1'b0;
      end

      accept_s = fetch.req_valid && req_ready_s;
   end

   // SERVE/LOAD controller with load pointer and word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_SERVE;
         ld_active_r <= 1'b0;
         ptr_r       <= {ADDR_W{1'b0}};
         ld_count_r  <= {(ADDR_W+1){1'b0}};
      end else begin
         case (state_r)
            ST_SERVE: begin
               if (ld_start) begin
                  ptr_r      <= ptr_step_s;
                  ld_count_r <= cnt_step_s;
                  if (load_done_s) begin
                     state_r     <= ST_SERVE;
                     ld_active_r <= 1'b0;
                  end else begin
                     state_r     <= ST_LOAD;
                     ld_active_r <= 1'b1;
                  end
               end else begin
                  state_r     <= ST_SERVE;
                  ld_active_r <= 1'b0;
               end
            end
            ST_LOAD: begin
               ptr_r      <= ptr_step_s;
               ld_count_r <= cnt_step_s;
               if (load_done_s) begin
                  state_r     <= ST_SERVE;
                  ld_active_r <= 1'b0;
               end else begin
                  state_r     <= ST_LOAD;
                  ld_active_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_SERVE;
               ld_active_r <= 1'b0;
               ptr_r       <= {ADDR_W{1'b0}};
               ld_count_r  <= {(ADDR_W+1){1'b0}};
            end
         endcase
      end
   end

   // Instruction storage; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (load_we_s) begin
         mem_r[eff_ptr_s] <= ld_data;
      end
   end

   // Response register: load on accept, hold while stalled, drop valid once taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_r <= 1'b0;
         resp_inst_r  <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         resp_valid_r <= 1'b1;
         resp_inst_r  <= mem_r[fetch.req_addr];
      end else if (fetch.resp_ready) begin
         resp_valid_r <= 1'b0;
         resp_inst_r  <= resp_inst_r;
      end else begin
         resp_valid_r <= resp_valid_r;
         resp_inst_r  <= resp_inst_r;
      end
   end

   assign fetch.req_ready  = req_ready_s;
   assign fetch.resp_valid = resp_valid_r;
   assign fetch.resp_inst  = resp_inst_r;
   assign ld_active        = ld_active_r;
   assign ld_count         = ld_count_r;

endmodule
